ctl_sequencer: RTL and testbench
================================

Name: ctl_sequencer

Overview:
Single-clock instruction sequencer that drives the branch/condition-code FSM. Per instruction it fetches a 16-bit word, decodes it, and issues the register write-enable, branch strobe and n/z/p mask. For branches it then consumes the returned taken decision (pc_ctl_0) and updates the PC. It sits between instruction memory, the register file/ALU and the condition-code/branch block.

Parameters:
PC_W, 16, program counter width
RESET_PC, 16'h3000, PC value after reset

Ports:
clka  in  1  system clock, all state updates on posedge
reset_n_in  in  1  asynchronous active-low reset
instr_req_out  out  1  instruction fetch request
instr_addr_out  out  PC_W  fetch address (equals pc_out while instr_req_out=1)
instr_valid_in  in  1  instruction word valid; completes fetch
instr_in  in  16  instruction word
base_in  in  PC_W  register-file read of BaseR (for JMP)
pc_ctl_0_in  in  1  branch taken decision from branch FSM
pc_out  out  PC_W  current PC
alu_op_out  out  2  00 ADD, 01 AND, 10 NOT, 11 LEA
dr_out  out  3  destination register (instr[11:9])
sr1_out  out  3  instr[8:6]
we_reg_out  out  1  register write enable, 1-cycle pulse
br_out  out  1  branch strobe, 1-cycle pulse
n_dec_out, z_dec_out, p_dec_out  out  1 each  branch condition mask (instr[11:9])
illegal_out  out  1  1-cycle pulse on unsupported opcode
state_out  out  3  current state encoding

Behaviour:
- Reset (async, reset_n_in=0): state=FETCH, pc_out=RESET_PC, instruction register=0, all pulse outputs and n/z/p_dec_out=0, alu_op_out=00, dr_out=sr1_out=0, instr_req_out=0. First request is asserted on the first clock after reset release.
- States: FETCH=000, DECODE=001, EXEC=010, BR_WAIT=011, HALT=100.
- FETCH: instr_req_out=1 and instr_addr_out=pc_out, held stable until instr_valid_in=1. On that edge: IR<=instr_in, pc_out<=pc_out+1 (modulo 2^PC_W, wraps 16'hFFFF->0), go to DECODE. Without valid, stay in FETCH indefinitely.
- DECODE: drive dr_out, sr1_out and alu_op_out from IR; these stay held until the next DECODE. Go to EXEC.
- EXEC, by opcode IR[15:12]:
  - 0001 ADD, 0101 AND, 1001 NOT, 1110 LEA: we_reg_out=1 for this cycle only; next state FETCH.
  - 0000 BR: br_out=1 for this cycle only. n/z/p_dec_out=IR[11:9], held through BR_WAIT. Next state BR_WAIT.
  - 1100 JMP: pc_out<=base_in; next state FETCH.
  - 1111 TRAP with IR[7:0]=8'h25: go to HALT.
  - Any other opcode: illegal_out=1 for this cycle only; next state FETCH. Treated as a NOP with no PC change.
- BR_WAIT: lasts exactly one cycle so the branch FSM can register its decision. On exit, if pc_ctl_0_in=1 then pc_out<=pc_out+sext(IR[8:0]), modulo 2^PC_W; otherwise PC is unchanged. Then n/z/p_dec_out<=0 and next state FETCH.
- BR with mask 000 still strobes br_out. The PC changes only if pc_ctl_0_in=1.
- HALT: absorbing state, no requests. Left only by reset.
- Reset asserted mid-fetch or mid-branch aborts immediately; an in-flight instr_valid_in is ignored.
- Instruction latency: ALU/JMP ops take 3 cycles plus fetch wait; BR takes 4 cycles plus fetch wait.

Test Plan:
- Reset release with instr_valid_in tied 1 and instr_in=16'h1042 (ADD R0,R1,R2) -> instr_addr_out=16'h3000; we_reg_out pulses exactly once, in the 3rd cycle; dr_out=0; alu_op_out=00; pc_out=16'h3001.
- BR nzp, offset -2 (16'h0FFE) at PC 16'h3005 with pc_ctl_0_in=1 in BR_WAIT -> br_out pulses once with n/z/p_dec_out=111; pc_out becomes 16'h3004.
- Same BR with pc_ctl_0_in=0 -> pc_out stays 16'h3006; dec outputs return to 0.
- JMP (16'hC080) with base_in=16'h4000 -> next instr_addr_out=16'h4000; no we_reg_out or br_out pulse.
- Fetch at PC 16'hFFFF with instr_valid_in delayed 5 cycles -> instr_req_out held 6 cycles with address stable; pc_out wraps to 16'h0000.
- Opcode 16'hD000 -> illegal_out pulses once. Then TRAP 16'hF025 -> state_out=100 and instr_req_out stays 0 until reset_n_in drops, after which state_out=000 and pc_out=16'h3000.

Source files
------------

// File: rtl/ctl_sequencer.sv
// Instruction sequencer: fetches and decodes 16-bit words, then issues register write, branch and mask controls.
// Pulse outputs are set on the edge into EXEC so they are high for exactly the EXEC cycle.
module ctl_sequencer #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(16'h3000)
) (
  input  logic            clka,
  input  logic            reset_n_in,
  output logic            instr_req_out,
  output logic [PC_W-1:0] instr_addr_out,
  input  logic            instr_valid_in,
  input  logic [15:0]     instr_in,
  input  logic [PC_W-1:0] base_in,
  input  logic            pc_ctl_0_in,
  output logic [PC_W-1:0] pc_out,
  output logic [1:0]      alu_op_out,
  output logic [2:0]      dr_out,
  output logic [2:0]      sr1_out,
  output logic            we_reg_out,
  output logic            br_out,
  output logic            n_dec_out,
  output logic            z_dec_out,
  output logic            p_dec_out,
  output logic            illegal_out,
  output logic [2:0]      state_out
);

  localparam int unsigned IR_W  = 16;
  localparam int unsigned OFF_W = 9;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;
  localparam logic [7:0] TRAP_HALT = 8'h25;

  typedef enum logic [2:0] {
    S_FETCH   = 3'b000,
    S_DECODE  = 3'b001,
    S_EXEC    = 3'b010,
    S_BR_WAIT = 3'b011,
    S_HALT    = 3'b100
  } state_t;

  state_t           state;
  logic [IR_W-1:0]  ir;
  logic [3:0]       opcode_c;
  logic             is_halt_c;
  logic [PC_W-1:0]  br_off_c;

  assign opcode_c  = ir[15:12];
  assign is_halt_c = (opcode_c == OP_TRAP) && (ir[7:0] == TRAP_HALT);
  assign br_off_c  = {{(PC_W-OFF_W){ir[OFF_W-1]}}, ir[OFF_W-1:0]};

  assign instr_addr_out = pc_out;
  assign state_out      = state;

  // ALU operation select; non-ALU opcodes default to ADD encoding
  function automatic logic [1:0] alu_sel(input logic [3:0] op);
    case (op)
      OP_AND:  alu_sel = 2'b01;
      OP_NOT:  alu_sel = 2'b10;
      OP_LEA:  alu_sel = 2'b11;
      default: alu_sel = 2'b00;
    endcase
  endfunction

  always_ff @(posedge clka or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state         <= S_FETCH;
      pc_out        <= RESET_PC;
      ir            <= '0;
      instr_req_out <= 1'b0;
      alu_op_out    <= 2'b00;
      dr_out        <= 3'b000;
      sr1_out       <= 3'b000;
      we_reg_out    <= 1'b0;
      br_out        <= 1'b0;
      illegal_out   <= 1'b0;
      n_dec_out     <= 1'b0;
      z_dec_out     <= 1'b0;
      p_dec_out     <= 1'b0;
    end else begin
      we_reg_out  <= 1'b0;
      br_out      <= 1'b0;
      illegal_out <= 1'b0;
      case (state)
        S_FETCH: begin
          // Request rises one cycle into FETCH after reset; valid only counts while requesting
          instr_req_out <= 1'b1;
          if (instr_req_out && instr_valid_in) begin
            ir            <= instr_in;
            pc_out        <= pc_out + PC_W'(1);
            instr_req_out <= 1'b0;
            state         <= S_DECODE;
          end
        end
        S_DECODE: begin
          dr_out     <= ir[11:9];
          sr1_out    <= ir[8:6];
          alu_op_out <= alu_sel(opcode_c);
          state      <= S_EXEC;
          case (opcode_c)
            OP_ADD, OP_AND, OP_NOT, OP_LEA: we_reg_out <= 1'b1;
            OP_BR: begin
              br_out    <= 1'b1;
              n_dec_out <= ir[11];
              z_dec_out <= ir[10];
              p_dec_out <= ir[9];
            end
            OP_JMP: ;
            default: illegal_out <= !is_halt_c;
          endcase
        end
        S_EXEC: begin
          if (opcode_c == OP_BR) begin
            state <= S_BR_WAIT;
          end else if (is_halt_c) begin
            state <= S_HALT;
          end else begin
            if (opcode_c == OP_JMP) pc_out <= base_in;
            instr_req_out <= 1'b1;
            state         <= S_FETCH;
          end
        end
        S_BR_WAIT: begin
          // Branch FSM decision is valid by now; PC already points past the branch
          if (pc_ctl_0_in) pc_out <= pc_out + br_off_c;
          n_dec_out     <= 1'b0;
          z_dec_out     <= 1'b0;
          p_dec_out     <= 1'b0;
          instr_req_out <= 1'b1;
          state         <= S_FETCH;
        end
        S_HALT: begin
          instr_req_out <= 1'b0;
        end
        default: begin
          instr_req_out <= 1'b0;
          state         <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctl_sequencer.sv
// Directed bench for ctl_sequencer: instruction table plus hand sequences for reset, wrap and halt.
module tb_ctl_sequencer;

  localparam int unsigned PC_W = 16;

  logic            clka = 1'b0;
  logic            reset_n_in;
  logic            instr_req_out;
  logic [PC_W-1:0] instr_addr_out;
  logic            instr_valid_in;
  logic [15:0]     instr_in;
  logic [PC_W-1:0] base_in;
  logic            pc_ctl_0_in;
  logic [PC_W-1:0] pc_out;
  logic [1:0]      alu_op_out;
  logic [2:0]      dr_out;
  logic [2:0]      sr1_out;
  logic            we_reg_out;
  logic            br_out;
  logic            n_dec_out;
  logic            z_dec_out;
  logic            p_dec_out;
  logic            illegal_out;
  logic [2:0]      state_out;

  ctl_sequencer #(.PC_W(PC_W), .RESET_PC(16'h3000)) dut (
    .clka           (clka),
    .reset_n_in     (reset_n_in),
    .instr_req_out  (instr_req_out),
    .instr_addr_out (instr_addr_out),
    .instr_valid_in (instr_valid_in),
    .instr_in       (instr_in),
    .base_in        (base_in),
    .pc_ctl_0_in    (pc_ctl_0_in),
    .pc_out         (pc_out),
    .alu_op_out     (alu_op_out),
    .dr_out         (dr_out),
    .sr1_out        (sr1_out),
    .we_reg_out     (we_reg_out),
    .br_out         (br_out),
    .n_dec_out      (n_dec_out),
    .z_dec_out      (z_dec_out),
    .p_dec_out      (p_dec_out),
    .illegal_out    (illegal_out),
    .state_out      (state_out)
  );

  always #5 clka = ~clka;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] base;
    logic        taken;
    logic [15:0] exp_addr;
    logic [15:0] exp_pc;
    int          exp_we;
    int          exp_br;
    int          exp_il;
    logic [2:0]  exp_nzp;
    logic [2:0]  exp_dr;
    logic [1:0]  exp_alu;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!instr_req_out && n < 20) begin
      @(negedge clka);
      n++;
    end
    if (!instr_req_out) chk({name, " req timeout"}, 32'(instr_req_out), 32'd1);
  endtask

  // Fetch one instruction and follow it until the next fetch request, tallying pulses
  task automatic run_vec(input int idx, input vec_t v);
    int we_c = 0, br_c = 0, il_c = 0, n = 0;
    logic [2:0] nzp = 3'b000;
    logic [15:0] addr;
    string tag;
    tag = $sformatf("v%0d", idx);
    wait_req(tag);
    addr           = instr_addr_out;
    instr_in       = v.instr;
    base_in        = v.base;
    pc_ctl_0_in    = v.taken;
    instr_valid_in = 1'b1;
    @(negedge clka);
    instr_valid_in = 1'b0;
    while (!instr_req_out && state_out != 3'b100 && n < 10) begin
      we_c += int'(we_reg_out);
      br_c += int'(br_out);
      il_c += int'(illegal_out);
      if (br_out) nzp = {n_dec_out, z_dec_out, p_dec_out};
      @(negedge clka);
      n++;
    end
    chk({tag, " addr"}, 32'(addr), 32'(v.exp_addr));
    chk({tag, " pc"}, 32'(pc_out), 32'(v.exp_pc));
    chk({tag, " we count"}, 32'(we_c), 32'(v.exp_we));
    chk({tag, " br count"}, 32'(br_c), 32'(v.exp_br));
    chk({tag, " illegal count"}, 32'(il_c), 32'(v.exp_il));
    chk({tag, " nzp"}, 32'(nzp), 32'(v.exp_nzp));
    chk({tag, " nzp cleared"}, 32'({n_dec_out, z_dec_out, p_dec_out}), 32'd0);
    chk({tag, " dr"}, 32'(dr_out), 32'(v.exp_dr));
    chk({tag, " alu_op"}, 32'(alu_op_out), 32'(v.exp_alu));
    chk({tag, " state"}, 32'(state_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        instr     base      tk    addr      pc        we br il nzp     dr    alu
    vecs[0]  = '{16'h5283, 16'h0000, 1'b0, 16'h3001, 16'h3002, 1, 0, 0, 3'b000, 3'd1, 2'b01};
    vecs[1]  = '{16'h9E7F, 16'h0000, 1'b0, 16'h3002, 16'h3003, 1, 0, 0, 3'b000, 3'd7, 2'b10};
    vecs[2]  = '{16'hE400, 16'h0000, 1'b0, 16'h3003, 16'h3004, 1, 0, 0, 3'b000, 3'd2, 2'b11};
    vecs[3]  = '{16'hD000, 16'h0000, 1'b0, 16'h3004, 16'h3005, 0, 0, 1, 3'b000, 3'd0, 2'b00};
    vecs[4]  = '{16'h0FFE, 16'h0000, 1'b1, 16'h3005, 16'h3004, 0, 1, 0, 3'b111, 3'd7, 2'b00};
    vecs[5]  = '{16'h1042, 16'h0000, 1'b0, 16'h3004, 16'h3005, 1, 0, 0, 3'b000, 3'd0, 2'b00};
    vecs[6]  = '{16'h0FFE, 16'h0000, 1'b0, 16'h3005, 16'h3006, 0, 1, 0, 3'b111, 3'd7, 2'b00};
    vecs[7]  = '{16'h0005, 16'h0000, 1'b1, 16'h3006, 16'h300C, 0, 1, 0, 3'b000, 3'd0, 2'b00};
    vecs[8]  = '{16'hC080, 16'h4000, 1'b0, 16'h300C, 16'h4000, 0, 0, 0, 3'b000, 3'd0, 2'b00};
    vecs[9]  = '{16'h1042, 16'h0000, 1'b0, 16'h4000, 16'h4001, 1, 0, 0, 3'b000, 3'd0, 2'b00};
    vecs[10] = '{16'hC1C0, 16'hFFFF, 1'b0, 16'h4001, 16'hFFFF, 0, 0, 0, 3'b000, 3'd0, 2'b00};

    reset_n_in     = 1'b0;
    instr_valid_in = 1'b1;
    instr_in       = 16'h1042;
    base_in        = '0;
    pc_ctl_0_in    = 1'b0;
    repeat (3) @(negedge clka);
    chk("reset state", 32'(state_out), 32'd0);
    chk("reset pc", 32'(pc_out), 32'h3000);
    chk("reset req", 32'(instr_req_out), 32'd0);
    chk("reset pulses", 32'({we_reg_out, br_out, illegal_out, n_dec_out, z_dec_out, p_dec_out}), 32'd0);

    // ADD with valid tied high from reset release: write pulse lands in cycle 3 only
    reset_n_in = 1'b1;
    @(negedge clka);
    chk("c1 req", 32'(instr_req_out), 32'd1);
    chk("c1 addr", 32'(instr_addr_out), 32'h3000);
    chk("c1 we", 32'(we_reg_out), 32'd0);
    @(negedge clka);
    instr_valid_in = 1'b0;
    chk("c2 we", 32'(we_reg_out), 32'd0);
    chk("c2 state", 32'(state_out), 32'b001);
    @(negedge clka);
    chk("c3 we", 32'(we_reg_out), 32'd1);
    chk("c3 state", 32'(state_out), 32'b010);
    chk("c3 dr", 32'(dr_out), 32'd0);
    chk("c3 sr1", 32'(sr1_out), 32'd1);
    chk("c3 alu", 32'(alu_op_out), 32'd0);
    chk("c3 pc", 32'(pc_out), 32'h3001);
    @(negedge clka);
    chk("c4 we", 32'(we_reg_out), 32'd0);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Stalled fetch at 0xFFFF: request and address hold until valid, then PC wraps
    wait_req("wrap");
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("wrap req c%0d", c), 32'(instr_req_out), 32'd1);
      chk($sformatf("wrap addr c%0d", c), 32'(instr_addr_out), 32'hFFFF);
      @(negedge clka);
    end
    chk("wrap req c5", 32'(instr_req_out), 32'd1);
    chk("wrap addr c5", 32'(instr_addr_out), 32'hFFFF);
    instr_in       = 16'h1042;
    instr_valid_in = 1'b1;
    @(negedge clka);
    instr_valid_in = 1'b0;
    chk("wrap pc", 32'(pc_out), 32'h0000);
    chk("wrap state", 32'(state_out), 32'b001);

    // TRAP x25 halts; only reset leaves
    wait_req("trap");
    chk("trap addr", 32'(instr_addr_out), 32'h0000);
    instr_in       = 16'hF025;
    instr_valid_in = 1'b1;
    @(negedge clka);
    instr_valid_in = 1'b0;
    @(negedge clka);
    chk("trap exec state", 32'(state_out), 32'b010);
    chk("trap no illegal", 32'(illegal_out), 32'd0);
    instr_valid_in = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clka);
      chk($sformatf("halt state c%0d", c), 32'(state_out), 32'b100);
      chk($sformatf("halt req c%0d", c), 32'(instr_req_out), 32'd0);
    end
    instr_valid_in = 1'b0;
    #2;
    reset_n_in = 1'b0;
    #1;
    chk("rst state", 32'(state_out), 32'd0);
    chk("rst pc", 32'(pc_out), 32'h3000);
    chk("rst req", 32'(instr_req_out), 32'd0);
    @(negedge clka);
    reset_n_in = 1'b1;
    @(negedge clka);
    chk("restart req", 32'(instr_req_out), 32'd1);
    chk("restart addr", 32'(instr_addr_out), 32'h3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
